// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size encoding, controller states and mapped RAM depth.
package mem_pkg;
   localparam int RAM_DEPTH = 1536;
   typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10} size_e;
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR, RESP} state_e;
   function automatic logic [1:0] last_idx(logic [1:0] size);
      return size == SIZE_B ? 2'd0 : size == SIZE_H ? 2'd1 : 2'd3;
   endfunction
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin grant; index 0 is fetch, index 1 is data.
module mem_arb_rr (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic last;
   logic pick;
   assign pick = &req ? ~last : req[1];
   assign gnt = en && |req ? (pick ? 2'b10 : 2'b01) : 2'b00;
   always_ff @(posedge clk)
      if (rst) last <= 1'b0;
      else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/ram_word_ctrl.sv
// ram_word_ctrl: serialises fetch and data accesses into byte-wide RAM cycles,
// packing read bytes little-endian and rejecting bad sizes, misalignment and out-of-range bases.
module ram_word_ctrl #(
   parameter int RAM_DEPTH = mem_pkg::RAM_DEPTH,
   parameter int ADDR_W    = 11
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic              IF_GNT,
   output logic              IF_DONE,
   output logic              IF_ERR,
   output logic [31:0]       IF_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [1:0]        D_SIZE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [31:0]       D_WDATA,
   output logic              D_GNT,
   output logic              D_DONE,
   output logic              D_ERR,
   output logic [31:0]       D_RDATA,
   output logic              RAM_RE,
   output logic [ADDR_W-1:0] RAM_RADDR,
   input  logic [7:0]        RAM_RDATA,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_WADDR,
   output logic [7:0]        RAM_WDATA
);
   import mem_pkg::*;
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(RAM_DEPTH);
   state_e state, nxt_state, st;
   logic [1:0] gnt, size, cnt, g_size;
   logic [ADDR_W-1:0] base, g_addr, cur;
   logic [31:0] wdata, buf_q, nxt_buf, rd_val;
   logic sel, err, g_err, last;
   mem_arb_rr u_arb (
      .clk(CLK),
      .rst(RST),
      .en(state == IDLE && !RST),
      .req({D_REQ, IF_REQ}),
      .gnt(gnt)
   );
   assign g_addr = gnt[1] ? D_ADDR : IF_ADDR;
   assign g_size = gnt[1] ? D_SIZE : SIZE_W;
   assign g_err = g_size == 2'b11 || (g_size == SIZE_H && g_addr[0]) ||
                  (g_size == SIZE_W && g_addr[1:0] != 2'b00) || {1'b0, g_addr} >= DEPTH;
   assign last = cnt == last_idx(size);
   assign cur = base + ADDR_W'(cnt);
   // While reset is held every output behaves as in IDLE.
   assign st = RST ? IDLE : state;
   assign IF_GNT = gnt[0];
   assign D_GNT = gnt[1];
   assign IF_DONE = st == RESP && !sel;
   assign D_DONE = st == RESP && sel;
   assign IF_ERR = IF_DONE && err;
   assign D_ERR = D_DONE && err;
   assign rd_val = state == RD_CAPT ? nxt_buf : '0;
   always_comb begin
      nxt_state = state;
      nxt_buf = buf_q;
      RAM_RE = 1'b0;
      RAM_RADDR = '0;
      RAM_WE = 1'b0;
      RAM_WADDR = '0;
      RAM_WDATA = '0;
      case (st)
         IDLE: nxt_state = !(|gnt) ? IDLE : g_err ? RESP : (gnt[1] && D_WE) ? WR : RD_ISSUE;
         RD_ISSUE: begin
            RAM_RE = 1'b1;
            RAM_RADDR = cur;
            nxt_state = RD_CAPT;
         end
         RD_CAPT: begin
            RAM_RE = 1'b1;
            RAM_RADDR = cur;
            nxt_buf[{cnt, 3'b000} +: 8] = RAM_RDATA;
            nxt_state = last ? RESP : RD_ISSUE;
         end
         WR: begin
            RAM_WE = 1'b1;
            RAM_WADDR = cur;
            RAM_WDATA = wdata[{cnt, 3'b000} +: 8];
            nxt_state = last ? RESP : WR;
         end
         RESP: nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end
   always_ff @(posedge CLK)
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
         sel <= 1'b0;
         err <= 1'b0;
         size <= '0;
         base <= '0;
         wdata <= '0;
         buf_q <= '0;
         IF_RDATA <= '0;
         D_RDATA <= '0;
      end else begin
         state <= nxt_state;
         buf_q <= state == IDLE ? '0 : nxt_buf;
         cnt <= (state == RD_CAPT || state == WR) && !last ? cnt + 2'd1 : state == IDLE ? '0 : cnt;
         if (|gnt) begin
            sel <= gnt[1];
            base <= g_addr;
            size <= g_size;
            err <= g_err;
            wdata <= D_WDATA;
         end
         // Read data becomes visible together with DONE and then holds.
         if (nxt_state == RESP) begin
            if (state == IDLE ? gnt[1] : sel) D_RDATA <= rd_val;
            else IF_RDATA <= rd_val;
         end
      end
endmodule

// File: doc/ram_word_ctrl.md
RAM_WORD_CTRL -- requirements
Module: ram_word_ctrl

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 1536, meaning number of mapped byte addresses.
REQ-002 SHALL have parameter ADDR_W, default 11, meaning byte-address width.
REQ-003 SHALL have port CLK, input, 1, the single clock; every register updates on the posedge.
REQ-004 SHALL have port RST, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have fetch ports: IF_REQ in 1, IF_ADDR in ADDR_W, IF_GNT out 1, IF_DONE out 1, IF_ERR out 1, IF_RDATA out 32.
REQ-006 SHALL have data ports: D_REQ in 1, D_WE in 1, D_SIZE in 2 (00 byte, 01 half, 10 word), D_ADDR in ADDR_W, D_WDATA in 32, D_GNT out 1, D_DONE out 1, D_ERR out 1, D_RDATA out 32.
REQ-007 SHALL have RAM ports: RAM_RE out 1, RAM_RADDR out ADDR_W, RAM_RDATA in 8, RAM_WE out 1, RAM_WADDR out ADDR_W, RAM_WDATA out 8.

Function
REQ-008 SHALL use FSM states IDLE, RD_ISSUE, RD_CAPT, WR, RESP.
REQ-009 IDLE: when a request is pending, SHALL pulse that port's GNT for 1 cycle, latch addr/size/we/wdata, set byte counter to 0, and go to RD_ISSUE, WR or RESP.
REQ-010 Simultaneous IF_REQ and D_REQ in IDLE SHALL grant the port not granted last; last-grant resets to IF, so the first conflict goes to data.
REQ-011 Fetch SHALL always be a 4-byte read; data byte count SHALL be 1/2/4 for D_SIZE 00/01/10.
REQ-012 D_SIZE 11, misalignment (half addr[0]!=0, word addr[1:0]!=0) or base addr >= RAM_DEPTH SHALL go IDLE->RESP with no RAM access; ERR pulses with DONE; RDATA is 0.
REQ-013 RD_ISSUE SHALL drive RAM_RE=1 and RAM_RADDR=base+cnt, then go to RD_CAPT.
REQ-014 RD_CAPT SHALL hold the same RAM_RE/RAM_RADDR and capture RAM_RDATA into lane cnt (bits 8cnt+7:8cnt, little-endian).
REQ-015 After RD_CAPT: last byte -> RESP, else cnt+1 -> RD_ISSUE.
REQ-016 WR SHALL drive RAM_WE=1, RAM_WADDR=base+cnt, RAM_WDATA=lane cnt of D_WDATA, one byte per cycle; last byte -> RESP.
REQ-017 RESP SHALL pulse DONE (and ERR if flagged) of the granted port for 1 cycle, then go to IDLE.
REQ-018 Latency from the GNT cycle to the DONE cycle: word read 9, half read 5, byte read 3, word write 5, half write 3, byte write 2, error 1.
REQ-019 Unused upper read lanes SHALL be zero (no sign extension).
REQ-020 IF_RDATA/D_RDATA SHALL update only in that port's RESP and hold until its next RESP.
REQ-021 RAM_RE and RAM_WE SHALL never both be 1; outside RD_* and WR, RAM_RE, RAM_WE and all RAM address/data outputs SHALL be 0.
REQ-022 Requesters hold REQ and operands until GNT; a REQ still high in IDLE after RESP is a new request.
REQ-023 Aligned accesses SHALL never wrap: base+cnt stays <= RAM_DEPTH-1.

Reset
REQ-024 RST SHALL force IDLE, cnt 0 and last-grant IF, and clear all outputs including RDATA.
REQ-025 RST mid-operation SHALL abort with no DONE; bytes already written stay written.

Structure
REQ-026 Package mem_pkg SHALL hold the size encoding (SIZE_B, SIZE_H, SIZE_W), the FSM state enum and RAM_DEPTH.
REQ-027 The 2-way round-robin grant SHALL be sub-module mem_arb_rr.
REQ-028 The RAM is not instantiated here; the top level connects the RAM_* ports to the 1536x8 banked block RAM.

Verification
REQ-029 Word write 0x11223344 @0x004, then word read @0x004 -> 4 WR cycles writing 0x44,0x33,0x22,0x11 to 0x004..0x007; D_DONE 5 cycles after GNT; read returns 0x11223344, D_DONE 9 cycles after GNT.
REQ-030 IF_REQ and D_REQ both high from reset, held until GNT -> D_GNT first; on D_REQ re-asserted at the next IDLE, IF_GNT wins; no port is granted twice while the other waits.
REQ-031 Word read @0x1FC..0x203 across the bank edge at 0x200 -> correct data; RAM_RADDR steady over each ISSUE/CAPT pair.
REQ-032 Half read @0x003 -> D_ERR with D_DONE 1 cycle after GNT, no RAM_RE/RAM_WE. Word write @0x600 -> D_ERR, no RAM_WE.
REQ-033 Byte read of 0xAB @0x5FF -> D_RDATA 0x000000AB, D_DONE 3 cycles after GNT.
REQ-034 RST after 2nd WR byte of a word write -> IDLE next cycle, no D_DONE, outputs 0; only the first 2 bytes are changed in RAM.
